seg_led_decoder: RTL and testbench

Receive-side counterpart of the 6-digit common-anode seven-segment driver. It samples the active-low digit-select and segment buses, which come either from an on-chip loopback or from an external board via input pins. It waits for each pattern to be stable, then decodes it back to a hex nibble, decimal point and blank/error flags. It assembles the decoded digits into a 6-digit frame, used for in-system self-check of display drivers and for bench scoreboarding.

---
 rtl/seg_led_decoder.sv | 235 +++++++++++++++++++++++
 tb/tb_seg_led_decoder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_led_decoder.sv
// Seven-segment bus receiver: recovers hex digits, dp, blank and error flags into a 6-digit frame.
// Optional macro SEG_DEC_TIMEOUT_EN discards partial frames that stay idle for TIMEOUT_CYC cycles.
module seg_led_decoder #(
  parameter logic [15:0] STABLE_CYC  = 16'd1000,
  parameter logic [25:0] TIMEOUT_CYC = 26'd50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  sel,
  input  logic [7:0]  seg_led,
  output logic [23:0] digits,
  output logic [5:0]  dp,
  output logic [5:0]  blank,
  output logic [5:0]  err,
  output logic        frame_valid,
  output logic        timeout
);

  // state    | meaning
  // S_IDLE   | no valid select seen; waiting for one
  // S_STABLE | counting consecutive identical sel/seg samples
  // S_HOLD   | pair captured; waiting for it to change
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_STABLE = 2'd1, S_HOLD = 2'd2} state_t;

  logic [5:0]  sel_s1_q, sel_s2_q;
  logic [7:0]  seg_s1_q, seg_s2_q;
  state_t      state_q, state_d;
  logic [5:0]  lat_sel_q, lat_sel_d;
  logic [7:0]  lat_seg_q, lat_seg_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  mask_q, mask_d;
  logic [23:0] sh_nib_q, sh_nib_d;
  logic [5:0]  sh_dp_q, sh_dp_d, sh_blank_q, sh_blank_d, sh_err_q, sh_err_d;
  logic [23:0] digits_q, digits_d;
  logic [5:0]  dp_q, dp_d, blank_q, blank_d, err_q, err_d;
  logic        frame_valid_q, frame_valid_d;

  logic        sel_valid, pair_same, load, capture;
  logic [5:0]  cap_slots;
  logic [3:0]  dec_nib;
  logic        dec_blank, dec_err;

`ifdef SEG_DEC_TIMEOUT_EN
  logic [25:0] idle_q, idle_d;
  logic        timeout_q, timeout_d;
`else
  logic        unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  // Broadcast (all low) inverts to every slot, so one expression covers both capture kinds.
  always_comb begin
    sel_valid = (sel_s2_q == 6'h00) || $onehot(~sel_s2_q);
    pair_same = (sel_s2_q == lat_sel_q) && (seg_s2_q == lat_seg_q);
    cap_slots = ~sel_s2_q;
  end

  always_comb begin
    dec_nib   = 4'h0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (seg_s2_q[6:0])
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0e: dec_nib = 4'hF;
      7'h7f: dec_blank = 1'b1;
      default: dec_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    lat_sel_d = lat_sel_q;
    lat_seg_d = lat_seg_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    capture   = 1'b0;
    case (state_q)
      S_IDLE: load = sel_valid;
      S_STABLE: begin
        if (pair_same) begin
          if (cnt_q < STABLE_CYC) cnt_d = cnt_q + 16'd1;
          if (cnt_d == STABLE_CYC) begin
            capture = 1'b1;
            state_d = S_HOLD;
          end
        end else if (sel_valid) begin
          load = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (!pair_same) begin
          if (sel_valid) load = 1'b1;
          else           state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A freshly latched pair is its own first sample; a window of one captures at once.
    if (load) begin
      lat_sel_d = sel_s2_q;
      lat_seg_d = seg_s2_q;
      cnt_d     = 16'd1;
      if (STABLE_CYC <= 16'd1) begin
        capture = 1'b1;
        state_d = S_HOLD;
      end else begin
        state_d = S_STABLE;
      end
    end
  end

  always_comb begin
    mask_d        = mask_q;
    sh_nib_d      = sh_nib_q;
    sh_dp_d       = sh_dp_q;
    sh_blank_d    = sh_blank_q;
    sh_err_d      = sh_err_q;
    digits_d      = digits_q;
    dp_d          = dp_q;
    blank_d       = blank_q;
    err_d         = err_q;
    frame_valid_d = 1'b0;
`ifdef SEG_DEC_TIMEOUT_EN
    idle_d        = '0;
    timeout_d     = 1'b0;
`endif
    if (capture) begin
      for (int i = 0; i < 6; i++) begin
        if (cap_slots[i]) begin
          sh_nib_d[i*4 +: 4] = dec_nib;
          sh_dp_d[i]         = ~seg_s2_q[7];
          sh_blank_d[i]      = dec_blank;
          sh_err_d[i]        = dec_err;
        end
      end
      mask_d = mask_q | cap_slots;
      if (mask_d == 6'h3f) begin
        digits_d      = sh_nib_d;
        dp_d          = sh_dp_d;
        blank_d       = sh_blank_d;
        err_d         = sh_err_d;
        frame_valid_d = 1'b1;
        mask_d        = 6'h00;
      end
    end
`ifdef SEG_DEC_TIMEOUT_EN
    else if (mask_q != 6'h00) begin
      idle_d = idle_q + 26'd1;
      if (idle_d == TIMEOUT_CYC) begin
        idle_d    = '0;
        mask_d    = 6'h00;
        timeout_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_s1_q      <= '0;
      sel_s2_q      <= '0;
      seg_s1_q      <= '0;
      seg_s2_q      <= '0;
      state_q       <= S_IDLE;
      lat_sel_q     <= '0;
      lat_seg_q     <= '0;
      cnt_q         <= '0;
      mask_q        <= '0;
      sh_nib_q      <= '0;
      sh_dp_q       <= '0;
      sh_blank_q    <= '0;
      sh_err_q      <= '0;
      digits_q      <= '0;
      dp_q          <= '0;
      blank_q       <= '0;
      err_q         <= '0;
      frame_valid_q <= 1'b0;
`ifdef SEG_DEC_TIMEOUT_EN
      idle_q        <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      sel_s1_q      <= sel;
      sel_s2_q      <= sel_s1_q;
      seg_s1_q      <= seg_led;
      seg_s2_q      <= seg_s1_q;
      state_q       <= state_d;
      lat_sel_q     <= lat_sel_d;
      lat_seg_q     <= lat_seg_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      sh_nib_q      <= sh_nib_d;
      sh_dp_q       <= sh_dp_d;
      sh_blank_q    <= sh_blank_d;
      sh_err_q      <= sh_err_d;
      digits_q      <= digits_d;
      dp_q          <= dp_d;
      blank_q       <= blank_d;
      err_q         <= err_d;
      frame_valid_q <= frame_valid_d;
`ifdef SEG_DEC_TIMEOUT_EN
      idle_q        <= idle_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign digits      = digits_q;
  assign dp          = dp_q;
  assign blank       = blank_q;
  assign err         = err_q;
  assign frame_valid = frame_valid_q;
`ifdef SEG_DEC_TIMEOUT_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_seg_led_decoder.sv
// Bench for seg_led_decoder: frame table, hand sequences, and random traffic against a run-length reference model.
module tb_seg_led_decoder;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  sel;
  logic [7:0]  seg_led;
  logic [23:0] digits;
  logic [5:0]  dp, blank, err;
  logic        frame_valid, timeout;

  seg_led_decoder #(.STABLE_CYC(16'd4), .TIMEOUT_CYC(26'd100)) dut (
    .clk(clk), .rst(rst), .sel(sel), .seg_led(seg_led),
    .digits(digits), .dp(dp), .blank(blank), .err(err),
    .frame_valid(frame_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int fv_cnt = 0;
  int to_cnt = 0;
  bit model_ok = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a digit is captured when a run of identical valid sel/seg samples reaches STABLE.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};
  logic [5:0]  d1_sel, d2_sel;
  logic [7:0]  d1_seg, d2_seg;
  logic [13:0] last_pair;
  int          run, idle;
  logic [3:0]  m_nib [6];
  logic        m_dp [6], m_blank [6], m_err [6];
  logic [5:0]  pend;
  logic [23:0] exp_digits;
  logic [5:0]  exp_dp, exp_blank, exp_err;
  logic        exp_fv, exp_to;

  function automatic int n_low(input logic [5:0] s);
    int c = 0;
    for (int k = 0; k < 6; k++) if (!s[k]) c++;
    return c;
  endfunction

  task automatic decode(input logic [7:0] s, output logic [3:0] n, output logic b, output logic e);
    n = 4'h0; b = 1'b0; e = 1'b1;
    if (s[6:0] == 7'h7f) begin
      b = 1'b1; e = 1'b0;
    end else begin
      for (int k = 0; k < 16; k++)
        if (seg_tab[k] == s[6:0]) begin n = k[3:0]; e = 1'b0; end
    end
  endtask

  task automatic model_step();
    logic [5:0] psel;
    logic [7:0] pseg;
    logic [3:0] n;
    logic b, e;
    bit cap;
    if (rst) begin
      d1_sel = '0; d2_sel = '0; d1_seg = '0; d2_seg = '0;
      last_pair = '0; run = 0; idle = 0; pend = '0;
      for (int k = 0; k < 6; k++) begin m_nib[k] = '0; m_dp[k] = 0; m_blank[k] = 0; m_err[k] = 0; end
      exp_digits = '0; exp_dp = '0; exp_blank = '0; exp_err = '0;
      exp_fv = 0; exp_to = 0;
      model_ok = 1'b1;
    end else begin
      psel = d2_sel; pseg = d2_seg;
      d2_sel = d1_sel; d2_seg = d1_seg;
      d1_sel = sel; d1_seg = seg_led;
      exp_fv = 0; exp_to = 0; cap = 0;
      if (psel == 6'h00 || n_low(psel) == 1) begin
        if (run > 0 && {psel, pseg} == last_pair) begin
          if (run <= STABLE) run++;
        end else begin
          run = 1;
        end
        last_pair = {psel, pseg};
        cap = (run == STABLE);
      end else begin
        run = 0;
      end
      if (cap) begin
        decode(pseg, n, b, e);
        for (int k = 0; k < 6; k++)
          if (!psel[k]) begin
            m_nib[k] = n; m_dp[k] = ~pseg[7]; m_blank[k] = b; m_err[k] = e;
            pend[k] = 1'b1;
          end
        idle = 0;
        if (pend == 6'h3f) begin
          for (int k = 0; k < 6; k++) begin
            exp_digits[k*4 +: 4] = m_nib[k];
            exp_dp[k] = m_dp[k]; exp_blank[k] = m_blank[k]; exp_err[k] = m_err[k];
          end
          exp_fv = 1;
          pend = '0;
        end
      end
`ifdef SEG_DEC_TIMEOUT_EN
      else if (pend != 6'h00) begin
        idle++;
        if (idle == TIMEOUT) begin
          pend = '0; exp_to = 1; idle = 0;
        end
      end
`endif
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      check("frame_valid", frame_valid, exp_fv);
      check("timeout", timeout, exp_to);
      check("digits", digits, exp_digits);
      check("dp_blank_err", {dp, blank, err}, {exp_dp, exp_blank, exp_err});
    end
    if (frame_valid === 1'b1) fv_cnt++;
    if (timeout === 1'b1) to_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic scan(input logic [47:0] pat, input int first, input int last, input int hold);
    for (int i = first; i <= last; i++) begin
      sel = ~(6'b1 << i);
      seg_led = pat[i*8 +: 8];
      step(hold);
    end
    sel = 6'h3f;
    seg_led = 8'hff;
  endtask

  typedef struct packed {
    logic [47:0] pat;
    logic [23:0] e_dig;
    logic [5:0]  e_dp;
    logic [5:0]  e_blank;
    logic [5:0]  e_err;
  } vec_t;
  vec_t vecs [3];

  task automatic run_vec(input int k);
    int f0;
    f0 = fv_cnt;
    scan(vecs[k].pat, 0, 5, 8);
    step(8);
    check("vec_frame_count", fv_cnt - f0, 1);
    check("vec_digits", digits, vecs[k].e_dig);
    check("vec_dp", dp, vecs[k].e_dp);
    check("vec_blank", blank, vecs[k].e_blank);
    check("vec_err", err, vecs[k].e_err);
  endtask

  initial begin
    int f0, t0, r;
    vecs[0] = '{pat: 48'h82_92_99_30_a4_c0, e_dig: 24'h654320, e_dp: 6'b000100, e_blank: 6'h00, e_err: 6'h00};
    vecs[1] = '{pat: 48'h88_c1_ff_90_80_f8, e_dig: 24'hA00987, e_dp: 6'h00, e_blank: 6'b001000, e_err: 6'b010000};
    vecs[2] = '{pat: 48'h79_8e_86_a1_c6_83, e_dig: 24'h1FEDCB, e_dp: 6'b100000, e_blank: 6'h00, e_err: 6'h00};

    rst = 1'b1; sel = 6'h3f; seg_led = 8'hff;
    step(3);
    rst = 1'b0;

    // Long idle: nothing captured.
    step(10000);
    check("idle_frames", fv_cnt, 0);
    check("idle_digits", digits, 24'h0);
    check("idle_flags", {dp, blank, err}, 18'h0);

    // Broadcast: frame pulse exactly 2 sync + STABLE cycles after the pattern appears.
    f0 = fv_cnt;
    sel = 6'h00; seg_led = 8'hf9;
    step(5);
    check("bcast_fv_early", frame_valid, 1'b0);
    step(1);
    check("bcast_fv_pulse", frame_valid, 1'b1);
    step(1);
    check("bcast_fv_after", frame_valid, 1'b0);
    step(3);
    sel = 6'h3f; seg_led = 8'hff;
    step(6);
    check("bcast_frame_count", fv_cnt - f0, 1);
    check("bcast_digits", digits, 24'h111111);
    check("bcast_flags", {dp, blank, err}, 18'h0);

    for (int k = 0; k < 3; k++) run_vec(k);

    // Glitch on digit 5 shorter than the window must not capture nor disturb the pending mask.
    f0 = fv_cnt;
    scan(vecs[0].pat, 0, 4, 8);
    sel = 6'b011111; seg_led = 8'hf9;
    step(3);
    sel = 6'h3f; seg_led = 8'hff;
    step(10);
    check("glitch_no_frame", fv_cnt - f0, 0);
    sel = 6'b011111; seg_led = 8'h99;
    step(8);
    sel = 6'h3f; seg_led = 8'hff;
    step(6);
    check("glitch_then_frame", fv_cnt - f0, 1);
    check("glitch_digits", digits, 24'h454320);
    check("glitch_dp", dp, 6'b000100);

    // Partial frame left idle.
    f0 = fv_cnt; t0 = to_cnt;
    scan(vecs[2].pat, 0, 2, 8);
    step(150);
`ifdef SEG_DEC_TIMEOUT_EN
    check("partial_timeout_count", to_cnt - t0, 1);
    check("partial_outputs_kept", digits, 24'h454320);
    scan(vecs[2].pat, 3, 5, 8);
    step(8);
    check("partial_discarded", fv_cnt - f0, 0);
    run_vec(2);
`else
    check("partial_timeout_count", to_cnt - t0, 0);
    scan(vecs[2].pat, 3, 5, 8);
    step(8);
    check("partial_persists", fv_cnt - f0, 1);
    check("partial_digits", digits, 24'h1FEDCB);
`endif

    // Reset mid-scan clears outputs and the pending mask.
    scan(vecs[1].pat, 0, 2, 8);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_digits", digits, 24'h0);
    check("rst_flags", {dp, blank, err}, 18'h0);
    f0 = fv_cnt;
    scan(vecs[1].pat, 3, 5, 8);
    step(8);
    check("rst_mask_cleared", fv_cnt - f0, 0);
    run_vec(1);

    // Random traffic, checked cycle by cycle against the model.
    for (int it = 0; it < 500; it++) begin
      r = $urandom_range(0, 9);
      if (r < 2)       sel = 6'h3f;
      else if (r < 7)  sel = ~(6'b1 << $urandom_range(0, 5));
      else if (r == 7) sel = 6'h00;
      else             sel = 6'($urandom);
      if ($urandom_range(0, 9) < 7) begin
        r = $urandom_range(0, 15);
        seg_led = {1'($urandom), seg_tab[r]};
      end else begin
        seg_led = 8'($urandom);
      end
      step($urandom_range(1, 7));
    end
    sel = 6'h3f; seg_led = 8'hff;
    step(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
